vram_blitter: RTL and testbench

Command-driven pixel writer for the double-buffered palette-index VRAM of the VGA display path. It accepts fill, sprite-blit and frame-swap commands through a ready/valid queue and walks only the target rectangle, not the whole frame. Pixels go out on the VRAM B-port as byte-enabled writes to the back bank, with edge clipping and transparent sprite pixels. Bank swaps are synchronised to vertical sync.

---
 rtl/vram_blitter.sv | 271 +++++++++++++++++++++++++++
 tb/tb_vram_blitter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_blitter.sv
// Command-queued pixel writer for the double-buffered palette VRAM.
// Walks FILL rectangles and sprite blits one pixel per cycle; swaps banks on vsync.
module vram_blitter #(
    parameter int FB_W         = 320,
    parameter int FB_H         = 240,
    parameter int PIX_BITS     = 8,
    parameter int PIX_PER_WORD = 4,
    parameter int SPR_SIZE     = 19,
    parameter int NUM_SPR      = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int ADDR_W       = 15,
    localparam int SPR_W       = $clog2(NUM_SPR),
    localparam int ROW_W       = $clog2(SPR_SIZE)
) (
    input  logic                             CLK,
    input  logic                             RESET_N,
    input  logic                             CMD_VALID,
    output logic                             CMD_READY,
    input  logic [1:0]                       CMD_OP,
    input  logic [8:0]                       CMD_X,
    input  logic [8:0]                       CMD_Y,
    input  logic [8:0]                       CMD_W,
    input  logic [8:0]                       CMD_H,
    input  logic [PIX_BITS-1:0]              CMD_IDX,
    input  logic [SPR_W-1:0]                 CMD_SPR,
    output logic [SPR_W+ROW_W-1:0]           SPR_ADDR,
    input  logic [SPR_SIZE-1:0]              SPR_ROW,
    input  logic                             VSYNC_PULSE,
    output logic                             WR_EN,
    output logic [ADDR_W-1:0]                WR_ADDR,
    output logic [PIX_BITS*PIX_PER_WORD-1:0] WR_DATA,
    output logic [PIX_PER_WORD-1:0]          WR_BYTEEN,
    output logic                             WR_BANK,
    output logic                             FRONT,
    output logic                             BUSY
);
    localparam int ENT_W   = 2 + 4 * 9 + PIX_BITS + SPR_W;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int PPW_LOG = $clog2(PIX_PER_WORD);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_ROW   = 3'd3;
    localparam logic [2:0] S_SWAP  = 3'd4;

    localparam logic [1:0] OP_FILL = 2'd0;
    localparam logic [1:0] OP_BLIT = 2'd1;
    localparam logic [1:0] OP_SWAP = 2'd2;

    // ---------------- command queue ----------------
    logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q, count_d;
    logic             ready_q;
    logic             push, pop;
    logic [2:0]       state_q, state_d;

    logic [1:0]          h_op;
    logic [8:0]          h_x, h_y, h_w, h_h;
    logic [PIX_BITS-1:0] h_idx;
    logic [SPR_W-1:0]    h_spr;

    assign push = CMD_VALID && ready_q;
    assign pop  = (state_q == S_IDLE) && (count_q != '0);
    assign {h_op, h_x, h_y, h_w, h_h, h_idx, h_spr} = fifo_mem[rd_ptr_q];

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {CMD_OP, CMD_X, CMD_Y, CMD_W, CMD_H, CMD_IDX, CMD_SPR};
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            ready_q <= (count_d != (PTR_W+1)'(FIFO_DEPTH));
        end
    end

    // ---------------- walker FSM ----------------
    logic [9:0]          base_x_q, base_x_d, base_y_q, base_y_d;
    logic [9:0]          ext_w_q, ext_w_d, ext_h_q, ext_h_d;
    logic [9:0]          ox_q, ox_d, oy_q, oy_d;
    logic [PIX_BITS-1:0] idx_q, idx_d;
    logic [SPR_W-1:0]    spr_q, spr_d;
    logic [SPR_SIZE-1:0] row_q, row_d, row_bits;
    logic [SPR_W+ROW_W-1:0] spr_addr_q, spr_addr_d;
    logic                front_q, front_d;
    logic                visit, pix_on;

    always_comb begin
        state_d    = state_q;
        base_x_d   = base_x_q;
        base_y_d   = base_y_q;
        ext_w_d    = ext_w_q;
        ext_h_d    = ext_h_q;
        ox_d       = ox_q;
        oy_d       = oy_q;
        idx_d      = idx_q;
        spr_d      = spr_q;
        row_d      = row_q;
        spr_addr_d = spr_addr_q;
        front_d    = front_q;
        visit      = 1'b0;
        pix_on     = 1'b1;
        // The store answers one cycle after FETCH, so column 0 uses the live row.
        row_bits   = (ox_q == '0) ? SPR_ROW : row_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    base_x_d = {1'b0, h_x};
                    base_y_d = {1'b0, h_y};
                    ox_d     = '0;
                    oy_d     = '0;
                    idx_d    = h_idx;
                    case (h_op)
                        OP_FILL: begin
                            ext_w_d = {1'b0, h_w};
                            ext_h_d = {1'b0, h_h};
                            if (h_w != '0 && h_h != '0) state_d = S_FILL;
                        end
                        OP_BLIT: begin
                            spr_d      = h_spr;
                            spr_addr_d = {h_spr, ROW_W'(0)};
                            state_d    = S_FETCH;
                        end
                        OP_SWAP: state_d = S_SWAP;
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_FILL: begin
                visit = 1'b1;
                if (ox_q == ext_w_q - 10'd1) begin
                    ox_d = '0;
                    if (oy_q == ext_h_q - 10'd1) state_d = S_IDLE;
                    else                         oy_d    = oy_q + 10'd1;
                end else begin
                    ox_d = ox_q + 10'd1;
                end
            end
            S_FETCH: begin
                ox_d    = '0;
                state_d = S_ROW;
            end
            S_ROW: begin
                visit  = 1'b1;
                pix_on = row_bits[0];
                row_d  = row_bits >> 1;
                if (ox_q == 10'(SPR_SIZE - 1)) begin
                    if (oy_q == 10'(SPR_SIZE - 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        oy_d       = oy_q + 10'd1;
                        spr_addr_d = {spr_q, ROW_W'(oy_q + 10'd1)};
                        state_d    = S_FETCH;
                    end
                end else begin
                    ox_d = ox_q + 10'd1;
                end
            end
            S_SWAP: begin
                if (VSYNC_PULSE) begin
                    front_d = ~front_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q    <= S_IDLE;
            base_x_q   <= '0;
            base_y_q   <= '0;
            ext_w_q    <= '0;
            ext_h_q    <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            idx_q      <= '0;
            spr_q      <= '0;
            row_q      <= '0;
            spr_addr_q <= '0;
            front_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_x_q   <= base_x_d;
            base_y_q   <= base_y_d;
            ext_w_q    <= ext_w_d;
            ext_h_q    <= ext_h_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            idx_q      <= idx_d;
            spr_q      <= spr_d;
            row_q      <= row_d;
            spr_addr_q <= spr_addr_d;
            front_q    <= front_d;
        end
    end

    // ---------------- write port ----------------
    logic [9:0]                       px, py;
    logic                             in_fb, wr_en_d;
    logic [PPW_LOG-1:0]               lane;
    logic [ADDR_W-1:0]                addr_d;
    logic [PIX_BITS*PIX_PER_WORD-1:0] data_d;
    logic [PIX_PER_WORD-1:0]          byteen_d;
    logic                             wr_en_q;
    logic [ADDR_W-1:0]                wr_addr_q;
    logic [PIX_BITS*PIX_PER_WORD-1:0] wr_data_q;
    logic [PIX_PER_WORD-1:0]          wr_byteen_q;

    assign px      = base_x_q + ox_q;
    assign py      = base_y_q + oy_q;
    assign in_fb   = (px < 10'(FB_W)) && (py < 10'(FB_H));
    assign wr_en_d = visit && pix_on && in_fb;
    assign lane    = px[PPW_LOG-1:0];
    assign addr_d  = ADDR_W'(py) * ADDR_W'(FB_W / PIX_PER_WORD) + ADDR_W'(px >> PPW_LOG);

    genvar gi;
    generate
        for (gi = 0; gi < PIX_PER_WORD; gi++) begin : g_lane
            assign data_d[gi*PIX_BITS +: PIX_BITS] = idx_q;
            assign byteen_d[gi]                    = (lane == PPW_LOG'(gi));
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_byteen_q <= '0;
        end else begin
            wr_en_q <= wr_en_d;
            if (wr_en_d) begin
                wr_addr_q   <= addr_d;
                wr_data_q   <= data_d;
                wr_byteen_q <= byteen_d;
            end
        end
    end

    assign CMD_READY = ready_q;
    assign SPR_ADDR  = spr_addr_q;
    assign WR_EN     = wr_en_q;
    assign WR_ADDR   = wr_addr_q;
    assign WR_DATA   = wr_data_q;
    assign WR_BYTEEN = wr_byteen_q;
    assign FRONT     = front_q;
    assign WR_BANK   = ~front_q;
    assign BUSY      = (state_q != S_IDLE) || (count_q != '0);
endmodule

// File: tb/tb_vram_blitter.sv
// Directed bench for vram_blitter: a rectangle/sprite model predicts every VRAM write,
// and literal checks pin latency, clipping, swap sync, backpressure and reset.
module tb_vram_blitter;
    localparam int FB_W = 320, FB_H = 240, PPW = 4, SS = 19;

    logic        clk = 1'b0;
    logic        rst_n, cmd_valid, cmd_ready, vsync;
    logic [1:0]  cmd_op;
    logic [8:0]  cmd_x, cmd_y, cmd_w, cmd_h;
    logic [7:0]  cmd_idx;
    logic [4:0]  cmd_spr;
    logic [9:0]  spr_addr;
    logic [18:0] spr_row = '0;
    logic        wr_en, wr_bank, front, busy;
    logic [14:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_byteen;

    always #5 clk = ~clk;

    vram_blitter dut (
        .CLK(clk), .RESET_N(rst_n), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
        .CMD_OP(cmd_op), .CMD_X(cmd_x), .CMD_Y(cmd_y), .CMD_W(cmd_w), .CMD_H(cmd_h),
        .CMD_IDX(cmd_idx), .CMD_SPR(cmd_spr), .SPR_ADDR(spr_addr), .SPR_ROW(spr_row),
        .VSYNC_PULSE(vsync), .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
        .WR_BYTEEN(wr_byteen), .WR_BANK(wr_bank), .FRONT(front), .BUSY(busy)
    );

    // Sprite 5 is a single left column; others get a row-dependent pattern.
    function automatic logic [18:0] spr_fn(input logic [4:0] s, input logic [4:0] r);
        if (s == 5'd5) return 19'h00001;
        return 19'h5A5A5 ^ ({14'd0, r} * 19'd37) ^ {14'd0, s};
    endfunction

    always @(posedge clk) spr_row <= spr_fn(spr_addr[9:5], spr_addr[4:0]);

    typedef struct packed {
        logic [14:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic        bank;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        obs_q[$];
    logic [9:0] sa_q[$];
    logic       mfront = 1'b0;
    int         n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic add_pix(input int x, input int y, input logic [7:0] idx);
        wr_t w;
        if (x < FB_W && y < FB_H) begin
            w.addr = 15'(y * (FB_W / PPW) + x / PPW);
            w.be   = 4'(1 << (x % PPW));
            w.data = {4{idx}};
            w.bank = !mfront;
            exp_q.push_back(w);
        end
    endtask

    // Commands run in queue order, so each one's writes follow all earlier swaps.
    task automatic model_cmd(input logic [1:0] op, input int x, input int y, input int w,
                             input int h, input logic [7:0] idx, input logic [4:0] spr);
        logic [18:0] bits;
        case (op)
            2'd0: for (int yy = 0; yy < h; yy++)
                      for (int xx = 0; xx < w; xx++) add_pix(x + xx, y + yy, idx);
            2'd1: for (int r = 0; r < SS; r++) begin
                      bits = spr_fn(spr, 5'(r));
                      for (int c = 0; c < SS; c++)
                          if (bits[c]) add_pix(x + c, y + r, idx);
                  end
            2'd2: mfront = !mfront;
            default: ;
        endcase
    endtask

    // Per-cycle compare against the model.
    initial begin
        logic [9:0] last_sa;
        wr_t e, o;
        last_sa = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("wr_bank_vs_front", wr_bank, !front);
                if (spr_addr != last_sa) begin
                    sa_q.push_back(spr_addr);
                    last_sa = spr_addr;
                end
                if (wr_en) begin
                    o.addr = wr_addr; o.be = wr_byteen; o.data = wr_data; o.bank = wr_bank;
                    obs_q.push_back(o);
                    if (exp_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_write: got addr %0d be %b, expected no write", wr_addr, wr_byteen);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", o.addr, e.addr);
                        chk("wr_byteen", o.be, e.be);
                        chk("wr_data", o.data, e.data);
                        chk("wr_bank", o.bank, e.bank);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [1:0] op, input int x, input int y, input int w,
                        input int h, input logic [7:0] idx, input logic [4:0] spr);
        int t;
        cmd_op = op; cmd_x = 9'(x); cmd_y = 9'(y); cmd_w = 9'(w); cmd_h = 9'(h);
        cmd_idx = idx; cmd_spr = spr; cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 500) begin @(negedge clk); t++; end
        if (t >= 500) begin
            n_chk++; n_fail++;
            $display("FAIL push_timeout: CMD_READY stayed 0, expected 1");
        end
        @(posedge clk);
        model_cmd(op, x, y, w, h, idx, spr);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op = 2'd1; cmd_x = 9'h155; cmd_y = 9'h0AA; cmd_w = 9'h1FF; cmd_h = 9'h1FF;
        cmd_idx = 8'hEE; cmd_spr = 5'd31;
    endtask

    // Counts BUSY cycles from the current negedge; also reports the first write cycle.
    task automatic measure(output int nbusy, output int first);
        int i;
        i = 0; first = -1;
        while (busy && i < 3000) begin
            if (wr_en && first < 0) first = i;
            i++;
            @(negedge clk);
        end
        if (i >= 3000) begin
            n_chk++; n_fail++;
            $display("FAIL busy_timeout: BUSY high %0d cycles, expected it to fall", i);
        end
        nbusy = i;
    endtask

    initial begin
        int nb, fw, acc, bad, cyc;
        logic saw_low, r;
        rst_n = 1'b0; cmd_valid = 1'b0; vsync = 1'b0;
        cmd_op = '0; cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_idx = '0; cmd_spr = '0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1); chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);     chk("rst_wr_data", wr_data, 0);
        chk("rst_wr_byteen", wr_byteen, 0); chk("rst_front", front, 0);
        chk("rst_wr_bank", wr_bank, 1);     chk("rst_busy", busy, 0);
        chk("rst_spr_addr", spr_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", cmd_ready, 1);

        // Single-row FILL
        obs_q.delete();
        push(2'd0, 6, 2, 3, 1, 8'h2A, 5'd0);
        measure(nb, fw);
        @(negedge clk);
        chk("fill1_busy_cycles", nb, 4);
        chk("fill1_first_write", fw, 2);
        chk("fill1_nwrites", obs_q.size(), 3);
        chk("fill1_w0_addr", obs_q[0].addr, 161); chk("fill1_w0_be", obs_q[0].be, 4'b0100);
        chk("fill1_w1_addr", obs_q[1].addr, 161); chk("fill1_w1_be", obs_q[1].be, 4'b1000);
        chk("fill1_w2_addr", obs_q[2].addr, 162); chk("fill1_w2_be", obs_q[2].be, 4'b0001);
        chk("fill1_data", obs_q[1].data, 32'h2A2A2A2A);
        chk("fill1_bank", obs_q[2].bank, 1);
        chk("fill1_drained", exp_q.size(), 0);

        // Clipped FILL at the bottom-right corner
        obs_q.delete();
        push(2'd0, 318, 239, 4, 2, 8'h77, 5'd0);
        measure(nb, fw);
        @(negedge clk);
        chk("clip_busy_cycles", nb, 9);
        chk("clip_nwrites", obs_q.size(), 2);
        chk("clip_w0_addr", obs_q[0].addr, 19199); chk("clip_w0_be", obs_q[0].be, 4'b0100);
        chk("clip_w1_addr", obs_q[1].addr, 19199); chk("clip_w1_be", obs_q[1].be, 4'b1000);
        chk("clip_drained", exp_q.size(), 0);

        // Zero-size FILL: no writes, pop cycle only
        obs_q.delete();
        push(2'd0, 10, 10, 0, 5, 8'h11, 5'd0);
        measure(nb, fw);
        @(negedge clk);
        chk("zero_busy_cycles", nb, 1);
        chk("zero_nwrites", obs_q.size(), 0);

        // Transparent BLIT of sprite 5 at origin
        obs_q.delete(); sa_q.delete();
        push(2'd1, 0, 0, 0, 0, 8'h3C, 5'd5);
        measure(nb, fw);
        @(negedge clk);
        chk("blit_busy_cycles", nb, 1 + 19 * 20);
        chk("blit_nwrites", obs_q.size(), 19);
        chk("blit_last_addr", obs_q[18].addr, 1440);
        chk("blit_be", obs_q[7].be, 4'b0001);
        chk("blit_nspraddr", sa_q.size(), 19);
        chk("blit_spraddr_first", sa_q[0], 10'd160);
        chk("blit_spraddr_last", sa_q[18], 10'd178);
        chk("blit_drained", exp_q.size(), 0);

        // Patterned BLIT clipped on both edges
        push(2'd1, 310, 230, 0, 0, 8'hC3, 5'd3);
        measure(nb, fw);
        @(negedge clk);
        chk("blit2_busy_cycles", nb, 381);
        chk("blit2_drained", exp_q.size(), 0);

        // Swap sync: early vsync ignored, FILL waits for the real one
        cmd_op = 2'd2; cmd_valid = 1'b1;
        @(posedge clk);
        model_cmd(2'd2, 0, 0, 0, 0, 8'h00, 5'd0);
        @(negedge clk);
        cmd_op = 2'd0; cmd_x = 9'd20; cmd_y = 9'd10; cmd_w = 9'd2; cmd_h = 9'd1; cmd_idx = 8'h99;
        vsync = 1'b1;
        @(posedge clk);
        model_cmd(2'd0, 20, 10, 2, 1, 8'h99, 5'd0);
        @(negedge clk);
        cmd_valid = 1'b0; vsync = 1'b0;
        bad = 0;
        for (int i = 0; i < 99; i++) begin
            @(negedge clk);
            if (front !== 1'b0 || wr_en !== 1'b0) bad++;
        end
        chk("swap_held_before_vsync", bad, 0);
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        chk("swap_front", front, 1);
        chk("swap_wr_bank", wr_bank, 0);
        measure(nb, fw);
        @(negedge clk);
        chk("swap_fill_busy", nb, 3);
        chk("swap_fill_first_write", fw, 2);
        chk("swap_drained", exp_q.size(), 0);

        // Backpressure while stalled in swap wait; six distinct 1x1 fills
        push(2'd2, 0, 0, 0, 0, 8'h00, 5'd0);
        repeat (3) @(negedge clk);
        acc = 0; cyc = 0; saw_low = 1'b0;
        while (acc < 6 && cyc < 60) begin
            cmd_op = 2'd0; cmd_x = 9'(10 + acc); cmd_y = 9'd50; cmd_w = 9'd1; cmd_h = 9'd1;
            cmd_idx = 8'(8'h10 + acc); cmd_valid = 1'b1;
            vsync = (cyc == 10);
            r = cmd_ready;
            if (!r && !saw_low) begin
                saw_low = 1'b1;
                chk("bp_accepted_before_drop", acc, 4);
            end
            @(posedge clk);
            if (r) begin
                model_cmd(2'd0, 10 + acc, 50, 1, 1, 8'(8'h10 + acc), 5'd0);
                acc++;
            end
            @(negedge clk);
            cyc++;
        end
        cmd_valid = 1'b0; vsync = 1'b0;
        chk("bp_ready_dropped", saw_low, 1);
        chk("bp_all_accepted", acc, 6);
        measure(nb, fw);
        @(negedge clk);
        chk("bp_drained", exp_q.size(), 0);
        chk("bp_front", front, 0);

        // Reset mid-stall flushes the queue and restores FRONT
        push(2'd2, 0, 0, 0, 0, 8'h00, 5'd0);
        repeat (2) @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        chk("pre_rst_front", front, 1);
        push(2'd2, 0, 0, 0, 0, 8'h00, 5'd0);
        repeat (2) @(negedge clk);
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            cmd_op = 2'd3; cmd_valid = 1'b1;
            r = cmd_ready;
            @(posedge clk);
            if (r) acc++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("nop_accepted", acc, 4);
        chk("nop_ready_low", cmd_ready, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete(); mfront = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", cmd_ready, 1);
        chk("midrst_front", front, 0);
        chk("midrst_wr_en", wr_en, 0);

        // Queue works again after reset
        obs_q.delete();
        push(2'd0, 0, 0, 1, 1, 8'h55, 5'd0);
        measure(nb, fw);
        @(negedge clk);
        chk("after_rst_busy", nb, 2);
        chk("after_rst_nwrites", obs_q.size(), 1);
        chk("after_rst_data", obs_q[0].data, 32'h55555555);
        chk("final_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
